// File: rtl/mac_seq_ctrl_5_pkg.sv
// Shared definitions for the multiplexed FP MAC sequencing controller:
// FSM states, step count and MAC status bit positions.
package mac_seq_ctrl_5_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int STEPS = 5;

   localparam int STAT_ZERO    = 0;
   localparam int STAT_INF     = 1;
   localparam int STAT_INVALID = 2;
   localparam int STAT_TINY    = 3;
   localparam int STAT_HUGE    = 4;
   localparam int STAT_INEXACT = 5;

endpackage

// File: rtl/mac_seq_ctrl_5.sv
// Steps a combinational 5-input FP MAC through select 0..4, feeding each result back
// as the next addend. Optional early abort on invalid status: MAC_SEQ_NAN_ABORT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a job, in_ready=1
// RUN     | driving MAC step 'step', accumulating result and status
// DONE    | out_valid=1 holding final result until out_ready
module mac_seq_ctrl_5
   import mac_seq_ctrl_5_pkg::*;
#(
   parameter int inst_sig_width = 23,
   parameter int inst_exp_width = 8,
   parameter int A_width        = inst_sig_width + inst_exp_width + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [A_width*5-1:0]   in_a,
   input  logic [A_width*5-1:0]   in_b,
   input  logic [A_width-1:0]     in_c,
   input  logic [2:0]             in_rnd,
   output logic [2:0]             mac_select,
   output logic [A_width*5-1:0]   mac_inst_a,
   output logic [A_width-1:0]     mac_inst_b,
   output logic [A_width-1:0]     mac_inst_c,
   output logic [2:0]             mac_inst_rnd,
   input  logic [A_width-1:0]     mac_z,
   input  logic [7:0]             mac_status,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [A_width-1:0]     out_z,
   output logic [7:0]             out_status
);

   state_t                 state;
   logic [2:0]             step;
   logic [A_width*5-1:0]   b_reg;
   logic [A_width-1:0]     acc;
   logic [7:0]             stat;
   logic                   last_step;

   assign mac_select = step;
   assign mac_inst_c = acc;

   always_comb begin
      mac_inst_b = b_reg[0 +: A_width];
      case (step)
         3'd1:    mac_inst_b = b_reg[A_width*1 +: A_width];
         3'd2:    mac_inst_b = b_reg[A_width*2 +: A_width];
         3'd3:    mac_inst_b = b_reg[A_width*3 +: A_width];
         3'd4:    mac_inst_b = b_reg[A_width*4 +: A_width];
         default: mac_inst_b = b_reg[0 +: A_width];
      endcase
   end

`ifdef MAC_SEQ_NAN_ABORT_EN
   assign last_step = (step == 3'(STEPS - 1)) || mac_status[STAT_INVALID];
`else
   assign last_step = (step == 3'(STEPS - 1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         step         <= '0;
         mac_inst_a   <= '0;
         b_reg        <= '0;
         mac_inst_rnd <= '0;
         acc          <= '0;
         stat         <= '0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         out_z        <= '0;
         out_status   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  mac_inst_a   <= in_a;
                  b_reg        <= in_b;
                  mac_inst_rnd <= in_rnd;
                  acc          <= in_c;
                  step         <= '0;
                  stat         <= '0;
                  in_ready     <= 1'b0;
                  state        <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc  <= mac_z;
               stat <= stat | mac_status;
               if (last_step) begin
                  // step returns to 0 so select/B idle at word 0 outside RUN
                  step       <= '0;
                  out_valid  <= 1'b1;
                  out_z      <= mac_z;
                  out_status <= stat | mac_status;
                  state      <= ST_DONE;
               end else begin
                  step <= step + 3'd1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mac_seq_ctrl_5.md
# mac_seq_ctrl_5

Sequencing controller directly upstream of the 5-input multiplexed FP MAC stage. Accepts one job of five A operands, five B operands, an initial addend and a rounding mode, and steps the MAC through select 0..4. Each step feeds the previous step's result back as the addend, producing z = c0 + Σ A[k]·B[k] with fused rounding at each step. Presents the final result and sticky status on a valid/ready output.

## Interface
- inst_sig_width, 23, significand width passed through to the MAC.
- inst_exp_width, 8, exponent width.
- A_width, inst_sig_width+inst_exp_width+1, FP word width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  job offered.
- in_ready  out  1  controller can accept a job (IDLE only).
- in_a  in  A_width*5  A operands; word k at [A_width*k +: A_width].
- in_b  in  A_width*5  B operands, same packing.
- in_c  in  A_width  initial addend.
- in_rnd  in  3  rounding mode, held for the whole job.
- mac_select  out  3  MAC select, 0..4 only.
- mac_inst_a  out  A_width*5  registered copy of in_a.
- mac_inst_b  out  A_width  B[k] for the current step.
- mac_inst_c  out  A_width  running accumulator.
- mac_inst_rnd  out  3  registered rounding mode.
- mac_z  in  A_width  MAC result, combinational from the mac_* outputs.
- mac_status  in  8  MAC status, combinational.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_z  out  A_width  final accumulator.
- out_status  out  8  OR of mac_status over every executed step.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register in_a, in_b, in_rnd; acc<=in_c; step<=0; stat<=0; go to RUN.
- RUN, step k: mac_select=k, mac_inst_b=B[k], mac_inst_c=acc. At the clock edge: acc<=mac_z; stat<=stat|mac_status. If k==4, go to DONE; otherwise step<=k+1.
- DONE: out_valid=1, out_z=acc, out_status=stat. On out_ready, go to IDLE.
- Outside RUN, mac_select=0 and mac_inst_b=B[0]. The controller never drives select values 5..7.
- The step counter is 3 bits and never wraps past 4.
- in_valid in RUN or DONE is ignored (in_ready=0). No input bypass.

## Timing
- Reset values: state IDLE; in_ready=1; out_valid=0; out_z, out_status, mac_select, mac_inst_* and acc all 0.
- Accept at edge E0. RUN occupies the cycles after E0..E4. out_valid rises after E5, giving a latency of 5 cycles from acceptance.
- out_z and out_status are stable while out_valid=1 and out_ready=0.
- Handshake at edge Ed in DONE: out_valid falls and in_ready rises after Ed. Next acceptance is possible no earlier than Ed+1. Throughput is one job per 7 cycles when out_ready is held high.
- rst asserted mid-job: immediate return to IDLE with reset values. The partial job is discarded and no output is produced.
- The MAC path is combinational. mac_z is sampled in the same cycle the controller drives its inputs.

## Configuration
- MAC_SEQ_NAN_ABORT_EN defined: if mac_status[2] (invalid) is 1 during any RUN step, capture that step's mac_z and status, then go directly to DONE. Remaining steps are skipped.
- MAC_SEQ_NAN_ABORT_EN undefined: all five steps always run. The invalid bit only accumulates into out_status.

## Structure
- Shared package holds:
  - the FSM state enum;
  - the STEPS=5 constant;
  - the status bit indices (STAT_ZERO=0, STAT_INF=1, STAT_INVALID=2, STAT_TINY=3, STAT_HUGE=4, STAT_INEXACT=5).
- No sub-module. The controller instantiates nothing. The MAC stage is connected beside it at the next level up.

## Test plan
- After reset: in_ready=1, out_valid=0, outputs 0. Then A[k]=1.0 (32'h3F800000), B[k]=2.0 (32'h40000000), c=0, rnd=0 → out_z=32'h41200000 (10.0) with out_valid rising 5 cycles after accept; out_status=0.
- Per-step check with the same job: mac_select follows 0,1,2,3,4 and mac_inst_c follows 0, 2.0, 4.0, 6.0, 8.0.
- Backpressure: hold out_ready=0 for 10 cycles → out_z held; in_valid pulsed during that time is not accepted. Then out_ready=1 → in_ready=1 on the next cycle.
- NaN propagation: A[2]=32'h7FC00000. Without the macro, out_valid comes 5 cycles after accept with out_status[2]=1. With MAC_SEQ_NAN_ABORT_EN, out_valid comes 3 cycles after accept with out_status[2]=1.
- Reset during RUN (step 2): assert rst asynchronously → state IDLE, in_ready=1 and out_valid=0 immediately. A fresh job afterwards completes correctly.
- Back-to-back jobs with out_ready tied high: accepts are 7 cycles apart and each out_z matches the reference model.
